// File: rtl/countdown_core.sv
// countdown_core: MM:SS.hh BCD countdown timer with prescaled hundredth tick.
// Ports: clk, rst (async active-low), load/load_val, start, pause pulses;
//   digits (BCD value), running, done (level), expire (1-cycle pulse).
module countdown_core #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [23:0] load_val,
    input  logic        start,
    input  logic        pause,
    output logic [23:0] digits,
    output logic        running,
    output logic        done,
    output logic        expire
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [23:0]   cnt;
    logic [23:0]   cnt_nxt;
    logic [23:0]   reload;
    logic [23:0]   reload_nxt;
    logic [PW-1:0] pre;
    logic [PW-1:0] pre_nxt;
    logic          expire_nxt;
    logic          load_ok;
    logic          start_ok;
    logic          tick;
    logic [23:0]   clamped;
    logic [23:0]   dec;

    // sec_t (digit 3) is limited to 5, every other digit to 9
    function automatic logic [23:0] clamp_bcd(input logic [23:0] v);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3)
                r[i*4+:4] = (v[i*4+:4] > 4'd5) ? 4'd5 : v[i*4+:4];
            else
                r[i*4+:4] = (v[i*4+:4] > 4'd9) ? 4'd9 : v[i*4+:4];
        end
        return r;
    endfunction

    // Ripple borrow from hs_o upward; a zero digit wraps to its max
    // and passes the borrow on. Zero input stays at zero.
    function automatic logic [23:0] dec_bcd(input logic [23:0] v);
        logic [23:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (v[i*4+:4] == 4'd0) begin
                    r[i*4+:4] = (i == 3) ? 4'd5 : 4'd9;
                end else begin
                    r[i*4+:4] = v[i*4+:4] - 4'd1;
                    borrow    = 1'b0;
                end
            end
        end
        if (v == 24'd0)
            r = 24'd0;
        return r;
    endfunction

    assign clamped = clamp_bcd(load_val);
    assign dec     = dec_bcd(cnt);

    // load beats start beats pause; a start that is not accepted
    // does not mask a pause
    assign load_ok  = load && (state != RUN);
    assign start_ok = start && !load_ok &&
                      (((state == IDLE) && (cnt != 24'd0)) ||
                       (state == DONE));
    assign tick     = (state == RUN) && (pre == PW'(TICK_DIV - 1));

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        if (load_ok) begin
            state_nxt = IDLE;
        end else if (start_ok) begin
            if (state == IDLE)
                state_nxt = RUN;
            else
                state_nxt = (reload != 24'd0) ? RUN : IDLE;
        end else if (state == RUN) begin
            // expiry wins over a coincident pause
            if (tick && (dec == 24'd0))
                state_nxt = DONE;
            else if (pause)
                state_nxt = PAUSE;
        end else if ((state == PAUSE) && pause) begin
            state_nxt = RUN;
        end
    end

    // datapath / output next values
    always_comb begin
        cnt_nxt    = cnt;
        reload_nxt = reload;
        pre_nxt    = pre;
        expire_nxt = 1'b0;
        if (load_ok) begin
            cnt_nxt    = clamped;
            reload_nxt = clamped;
            pre_nxt    = '0;
        end else if (start_ok) begin
            pre_nxt = '0;
            if (state == DONE)
                cnt_nxt = reload;
        end else if (state == RUN) begin
            pre_nxt = tick ? '0 : pre + PW'(1);
            if (tick) begin
                cnt_nxt    = dec;
                expire_nxt = (dec == 24'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            reload  <= '0;
            pre     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            expire  <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            reload  <= reload_nxt;
            pre     <= pre_nxt;
            running <= (state_nxt == RUN);
            done    <= (state_nxt == DONE);
            expire  <= expire_nxt;
        end
    end

    assign digits = cnt;

endmodule

// File: tb/tb_countdown_core.sv
// tb_countdown_core: directed and random checks of countdown_core
// against a hundredths-of-a-second reference model.
module tb_countdown_core;

    localparam int TD = 4;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [23:0] load_val = '0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [23:0] digits;
    logic        running;
    logic        done;
    logic        expire;

    int nerr = 0;
    int nchk = 0;

    int mst  = S_IDLE;
    int mval = 0;
    int mrel = 0;
    int mpre = 0;
    bit mexp = 1'b0;

    countdown_core #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .digits(digits),
        .running(running), .done(done), .expire(expire)
    );

    always #5 clk = ~clk;

    // BCD word -> total hundredths, with per-digit limiting applied
    function automatic int to_h(input logic [23:0] v);
        int d[6];
        logic [23:0] w;
        w = v;
        for (int i = 0; i < 6; i++) begin
            d[i] = int'(w[i*4+:4]);
            if (i == 3 && d[i] > 5) d[i] = 5;
            if (i != 3 && d[i] > 9) d[i] = 9;
        end
        return ((d[5] * 10 + d[4]) * 60 + d[3] * 10 + d[2]) * 100
               + d[1] * 10 + d[0];
    endfunction

    function automatic logic [23:0] to_bcd(input int t);
        int mm, ss, hh;
        mm = t / 6000;
        ss = (t / 100) % 60;
        hh = t % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                4'(hh / 10), 4'(hh % 10)};
    endfunction

    task automatic model_reset();
        mst = S_IDLE; mval = 0; mrel = 0; mpre = 0; mexp = 1'b0;
    endtask

    task automatic model(input bit l, input logic [23:0] lv,
                         input bit s, input bit p);
        mexp = 1'b0;
        if (l && mst != S_RUN) begin
            mval = to_h(lv); mrel = mval; mst = S_IDLE; mpre = 0;
        end else if (s && mst == S_IDLE) begin
            if (mval != 0) begin mst = S_RUN; mpre = 0; end
        end else if (s && mst == S_DONE) begin
            mval = mrel; mpre = 0;
            mst = (mrel != 0) ? S_RUN : S_IDLE;
        end else if (mst == S_RUN) begin
            if (mpre == TD - 1) begin
                mpre = 0;
                mval = mval - 1;
                if (mval == 0) begin mst = S_DONE; mexp = 1'b1; end
            end else begin
                mpre++;
            end
            if (p && mst == S_RUN) mst = S_PAUSE;
        end else if (p && mst == S_PAUSE) begin
            mst = S_RUN;
        end
    endtask

    task automatic chk(input string tag, input logic [23:0] obs,
                       input logic [23:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("digits", digits, to_bcd(mval));
        chk("running", {23'b0, running}, 24'(mst == S_RUN));
        chk("done", {23'b0, done}, 24'(mst == S_DONE));
        chk("expire", {23'b0, expire}, 24'(mexp));
    endtask

    task automatic step(input bit l, input logic [23:0] lv,
                        input bit s, input bit p);
        load = l; load_val = lv; start = s; pause = p;
        @(posedge clk);
        model(l, lv, s, p);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0);
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        chk("rst_digits", digits, 24'h000000);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        step(1, 24'h012345, 0, 0);
        chk("load_val", digits, 24'h012345);
        chk("load_idle", {23'b0, running}, 24'h0);

        // borrow chain through every digit
        step(1, 24'h010000, 0, 0);
        step(0, '0, 1, 0);
        idle(4);
        chk("borrow1", digits, 24'h005999);
        idle(4);
        chk("borrow2", digits, 24'h005998);
        idle(2);

        // asynchronous reset mid-count
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("arst_digits", digits, 24'h000000);
        chk("arst_run", {23'b0, running}, 24'h0);
        @(negedge clk);
        rst = 1'b1;
        idle(6);

        step(1, 24'hAB7FCD, 0, 0);
        chk("clamp", digits, 24'h995999);

        // expiry
        step(1, 24'h000002, 0, 0);
        step(0, '0, 1, 0);
        idle(4);
        chk("exp_1", digits, 24'h000001);
        idle(4);
        chk("exp_0", digits, 24'h000000);
        chk("exp_pulse", {23'b0, expire}, 24'h1);
        idle(1);
        chk("exp_drop", {23'b0, expire}, 24'h0);
        chk("done_held", {23'b0, done}, 24'h1);
        idle(8);
        chk("exp_stay0", digits, 24'h000000);

        // restart from DONE
        step(1, 24'h000003, 0, 0);
        step(0, '0, 1, 0);
        idle(12);
        chk("done3", {23'b0, done}, 24'h1);
        step(0, '0, 1, 0);
        chk("restart_val", digits, 24'h000003);
        chk("restart_run", {23'b0, running}, 24'h1);
        step(0, '0, 0, 1);
        step(1, 24'h000000, 0, 0);
        step(0, '0, 1, 0);
        chk("zero_start", {23'b0, running}, 24'h0);
        step(1, 24'h000042, 1, 0);
        chk("ld_st_val", digits, 24'h000042);
        chk("ld_st_run", {23'b0, running}, 24'h0);

        // pause preserves prescaler phase
        step(1, 24'h000050, 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 1);
        idle(20);
        chk("paused", digits, 24'h000050);
        step(0, '0, 0, 1);
        step(0, '0, 0, 0);
        chk("resume1", digits, 24'h000050);
        step(0, '0, 0, 0);
        chk("resume2", digits, 24'h000049);

        // random pulses against the model
        for (int i = 0; i < 2500; i++) begin
            logic [23:0] lv;
            bit l, s, p;
            l = ($urandom_range(0, 19) == 0);
            s = ($urandom_range(0, 9) == 0);
            p = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 2) == 0)
                lv = 24'($urandom_range(0, 40));
            else
                lv = 24'($urandom);
            step(l, lv, s, p);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
